// File: rtl/ll_data_table_ctrl.sv
// Linked-list hash table data-RAM controller: dispatches one task at a time to
// search/insert/delete engines. Optional counters: LL_DATA_TABLE_CTRL_STATS_EN.
package ll_pkg;
  localparam int LL_TABLE_ADDR_WIDTH = 8;

  typedef logic [1:0] ll_opcode_t;
  localparam ll_opcode_t OP_SEARCH = 2'd0;
  localparam ll_opcode_t OP_INSERT = 2'd1;
  localparam ll_opcode_t OP_DELETE = 2'd2;

  typedef logic [2:0] ll_rescode_t;
  localparam ll_rescode_t LL_SEARCH_FOUND                 = 3'd0;
  localparam ll_rescode_t LL_SEARCH_NOT_FOUND             = 3'd1;
  localparam ll_rescode_t LL_INSERT_SUCCESS               = 3'd2;
  localparam ll_rescode_t LL_INSERT_NOT_SUCCESS_TABLE_FULL = 3'd3;
  localparam ll_rescode_t LL_DELETE_SUCCESS               = 3'd4;
  localparam ll_rescode_t LL_DELETE_NOT_SUCCESS_NO_ENTRY  = 3'd5;

  typedef logic [2:0] ll_chain_state_t;
  localparam ll_chain_state_t LL_NO_CHAIN     = 3'd0;
  localparam ll_chain_state_t LL_IN_HEAD      = 3'd1;
  localparam ll_chain_state_t LL_IN_MIDDLE    = 3'd2;
  localparam ll_chain_state_t LL_IN_TAIL      = 3'd3;
  localparam ll_chain_state_t LL_IN_HEAD_TAIL = 3'd4;

  typedef struct packed {
    ll_opcode_t  opcode;
    logic [15:0] key;
    logic [15:0] value;
  } ll_cmd_t;

  typedef struct packed {
    ll_cmd_t                        cmd;
    logic [LL_TABLE_ADDR_WIDTH-1:0] head_ptr;
    logic                           head_ptr_val;
  } ll_ht_pdata_t;

  typedef struct packed {
    logic [15:0]                    key;
    logic [15:0]                    value;
    logic [LL_TABLE_ADDR_WIDTH-1:0] next_ptr;
    logic                           next_ptr_val;
  } ll_ram_data_t;

  typedef struct packed {
    ll_cmd_t         cmd;
    ll_rescode_t     rescode;
    ll_chain_state_t chain_state;
  } ll_ht_result_t;
endpackage

module ll_data_table_ctrl
  import ll_pkg::*;
#(
  parameter int RAM_LATENCY = 2,
  parameter int A_WIDTH     = LL_TABLE_ADDR_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  ll_ht_pdata_t              task_i,
  input  logic                      task_valid_i,
  output logic                      task_ready_o,
  output ll_ht_pdata_t              eng_task_o,
  output logic [2:0]                eng_task_valid_o,
  input  logic [2:0]                eng_task_ready_i,
  input  logic [2:0][A_WIDTH-1:0]   eng_rd_addr_i,
  input  logic [2:0]                eng_rd_en_i,
  input  logic [2:0][A_WIDTH-1:0]   eng_wr_addr_i,
  input  ll_ram_data_t [2:0]        eng_wr_data_i,
  input  logic [2:0]                eng_wr_en_i,
  output logic [A_WIDTH-1:0]        rd_addr_o,
  output logic                      rd_en_o,
  output logic [A_WIDTH-1:0]        wr_addr_o,
  output ll_ram_data_t              wr_data_o,
  output logic                      wr_en_o,
  input  ll_ht_result_t [2:0]       eng_result_i,
  input  logic [2:0]                eng_result_valid_i,
  output logic [2:0]                eng_result_ready_o,
  output ll_ht_result_t             result_o,
  output logic                      result_valid_o,
  input  logic                      result_ready_i,
  output logic                      busy_o,
  output logic                      proto_err_o
`ifdef LL_DATA_TABLE_CTRL_STATS_EN
  ,
  output logic [31:0]               stat_search_o,
  output logic [31:0]               stat_insert_o,
  output logic [31:0]               stat_delete_o
`endif
);

  if (RAM_LATENCY < 0) begin : g_lat_chk
    $error("RAM_LATENCY must be non-negative");
  end

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    WAIT_RES,
    BAD_OP
  } state_e;

  state_e       state_q, state_d;
  logic [2:0]   sel_q, sel_d;
  ll_ht_pdata_t task_q, task_d;
  logic         proto_err_q, proto_err_d;
  logic [2:0]   dec_sel;
  logic         dec_legal;
  logic [2:0]   grant;
  logic [1:0]   idx;
  logic [2:0]   stray;

  always_comb begin
    dec_sel   = 3'b000;
    dec_legal = 1'b0;
    unique case (task_i.cmd.opcode)
      OP_SEARCH: begin dec_sel = 3'b001; dec_legal = 1'b1; end
      OP_INSERT: begin dec_sel = 3'b010; dec_legal = 1'b1; end
      OP_DELETE: begin dec_sel = 3'b100; dec_legal = 1'b1; end
      default:   ;
    endcase
  end

  always_comb begin
    idx = 2'd0;
    unique case (1'b1)
      sel_q[1]: idx = 2'd1;
      sel_q[2]: idx = 2'd2;
      default:  idx = 2'd0;
    endcase
  end

  // Only the engine owning the current task may touch the RAM or report.
  assign grant = (state_q == DISPATCH || state_q == WAIT_RES) ? sel_q : 3'b000;
  assign stray = (eng_rd_en_i | eng_wr_en_i | eng_result_valid_i) & ~grant;
  assign proto_err_d = proto_err_q | (|stray);

  assign rd_addr_o = eng_rd_addr_i[idx];
  assign rd_en_o   = |(eng_rd_en_i & grant);
  assign wr_addr_o = eng_wr_addr_i[idx];
  assign wr_data_o = eng_wr_data_i[idx];
  assign wr_en_o   = |(eng_wr_en_i & grant);

  assign task_ready_o = rst_n_i && (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign eng_task_o   = task_q;
  assign proto_err_o  = proto_err_q;

  always_comb begin
    state_d            = state_q;
    sel_d              = sel_q;
    task_d             = task_q;
    eng_task_valid_o   = 3'b000;
    eng_result_ready_o = 3'b000;
    result_o           = '0;
    result_valid_o     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (task_valid_i) begin
          task_d  = task_i;
          sel_d   = dec_sel;
          state_d = dec_legal ? DISPATCH : BAD_OP;
        end
      end
      DISPATCH: begin
        eng_task_valid_o = sel_q;
        if (|(eng_task_ready_i & sel_q)) state_d = WAIT_RES;
      end
      WAIT_RES: begin
        result_o           = eng_result_i[idx];
        result_valid_o     = eng_result_valid_i[idx];
        eng_result_ready_o = sel_q & {3{result_ready_i}};
        if (eng_result_valid_i[idx] && result_ready_i) begin
          state_d = IDLE;
          sel_d   = 3'b000;
        end
      end
      BAD_OP: begin
        result_valid_o       = 1'b1;
        result_o.cmd         = task_q.cmd;
        result_o.rescode     = LL_DELETE_NOT_SUCCESS_NO_ENTRY;
        result_o.chain_state = LL_NO_CHAIN;
        if (result_ready_i) begin
          state_d = IDLE;
          sel_d   = 3'b000;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      sel_q       <= 3'b000;
      task_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      task_q      <= task_d;
      proto_err_q <= proto_err_d;
    end
  end

`ifdef LL_DATA_TABLE_CTRL_STATS_EN
  logic [2:0][31:0] stat_q;
  logic [2:0]       res_hs;

  assign res_hs = (state_q == WAIT_RES && result_ready_i) ?
                  (sel_q & eng_result_valid_i) : 3'b000;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stat_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (res_hs[i]) stat_q[i] <= stat_q[i] + 32'd1;
      end
    end
  end

  assign stat_search_o = stat_q[0];
  assign stat_insert_o = stat_q[1];
  assign stat_delete_o = stat_q[2];
`endif

endmodule

// File: tb/tb_ll_data_table_ctrl.sv
// Directed self-checking bench for ll_data_table_ctrl.
// Stats checks compile only with LL_DATA_TABLE_CTRL_STATS_EN.
module tb_ll_data_table_ctrl;
  import ll_pkg::*;

  localparam int AW = LL_TABLE_ADDR_WIDTH;

  logic                  clk_i = 1'b0;
  logic                  rst_n_i;
  ll_ht_pdata_t          task_i;
  logic                  task_valid_i;
  logic                  task_ready_o;
  ll_ht_pdata_t          eng_task_o;
  logic [2:0]            eng_task_valid_o;
  logic [2:0]            eng_task_ready_i;
  logic [2:0][AW-1:0]    eng_rd_addr_i;
  logic [2:0]            eng_rd_en_i;
  logic [2:0][AW-1:0]    eng_wr_addr_i;
  ll_ram_data_t [2:0]    eng_wr_data_i;
  logic [2:0]            eng_wr_en_i;
  logic [AW-1:0]         rd_addr_o;
  logic                  rd_en_o;
  logic [AW-1:0]         wr_addr_o;
  ll_ram_data_t          wr_data_o;
  logic                  wr_en_o;
  ll_ht_result_t [2:0]   eng_result_i;
  logic [2:0]            eng_result_valid_i;
  logic [2:0]            eng_result_ready_o;
  ll_ht_result_t         result_o;
  logic                  result_valid_o;
  logic                  result_ready_i;
  logic                  busy_o;
  logic                  proto_err_o;
`ifdef LL_DATA_TABLE_CTRL_STATS_EN
  logic [31:0]           stat_search_o;
  logic [31:0]           stat_insert_o;
  logic [31:0]           stat_delete_o;
`endif

  int compared = 0;
  int mismatched = 0;

  ll_data_table_ctrl dut (
    .clk_i              (clk_i),
    .rst_n_i            (rst_n_i),
    .task_i             (task_i),
    .task_valid_i       (task_valid_i),
    .task_ready_o       (task_ready_o),
    .eng_task_o         (eng_task_o),
    .eng_task_valid_o   (eng_task_valid_o),
    .eng_task_ready_i   (eng_task_ready_i),
    .eng_rd_addr_i      (eng_rd_addr_i),
    .eng_rd_en_i        (eng_rd_en_i),
    .eng_wr_addr_i      (eng_wr_addr_i),
    .eng_wr_data_i      (eng_wr_data_i),
    .eng_wr_en_i        (eng_wr_en_i),
    .rd_addr_o          (rd_addr_o),
    .rd_en_o            (rd_en_o),
    .wr_addr_o          (wr_addr_o),
    .wr_data_o          (wr_data_o),
    .wr_en_o            (wr_en_o),
    .eng_result_i       (eng_result_i),
    .eng_result_valid_i (eng_result_valid_i),
    .eng_result_ready_o (eng_result_ready_o),
    .result_o           (result_o),
    .result_valid_o     (result_valid_o),
    .result_ready_i     (result_ready_i),
    .busy_o             (busy_o),
    .proto_err_o        (proto_err_o)
`ifdef LL_DATA_TABLE_CTRL_STATS_EN
    ,
    .stat_search_o      (stat_search_o),
    .stat_insert_o      (stat_insert_o),
    .stat_delete_o      (stat_delete_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic clr();
    task_i             = '0;
    task_valid_i       = 1'b0;
    eng_task_ready_i   = 3'b000;
    eng_rd_addr_i      = '0;
    eng_rd_en_i        = 3'b000;
    eng_wr_addr_i      = '0;
    eng_wr_data_i      = '0;
    eng_wr_en_i        = 3'b000;
    eng_result_i       = '0;
    eng_result_valid_i = 3'b000;
    result_ready_i     = 1'b0;
  endtask

  // Presents a task for one accept edge; returns 1ns into the first
  // cycle after acceptance.
  task automatic send_task(input ll_opcode_t op, input logic [15:0] key);
    @(negedge clk_i);
    task_i = '0;
    task_i.cmd.opcode = op;
    task_i.cmd.key = key;
    task_i.cmd.value = ~key;
    task_i.head_ptr = 8'h40;
    task_i.head_ptr_val = 1'b1;
    task_valid_i = 1'b1;
    @(negedge clk_i);
    task_valid_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    clr();
    #1;
    compared++;
    if ({task_ready_o, busy_o, eng_task_valid_o, rd_en_o, wr_en_o,
         result_valid_o, proto_err_o, eng_result_ready_o} !== 11'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: got rdy=%b busy=%b etv=%b rd=%b wr=%b rv=%b err=%b err_rdy=%b want all 0",
               task_ready_o, busy_o, eng_task_valid_o, rd_en_o, wr_en_o,
               result_valid_o, proto_err_o, eng_result_ready_o);
    end
    compared++;
    if (eng_task_o !== '0) begin
      mismatched++;
      $display("FAIL reset_task: got %h want 0", eng_task_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
    compared++;
    if (task_ready_o !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_release_ready: got %b want 1", task_ready_o);
    end
  endtask

  task automatic test_search();
    int nvalid;
    ll_ht_result_t res;
    nvalid = 0;
    send_task(OP_SEARCH, 16'h1234);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk_i);
      eng_task_ready_i = (c == 2) ? 3'b001 : 3'b000;
      eng_rd_en_i = 3'b001;
      eng_rd_addr_i[0] = 8'h20 + 8'(c);
      eng_rd_addr_i[1] = 8'hEE;
      #1;
      if (eng_task_valid_o === 3'b001) nvalid++;
      compared++;
      if (rd_en_o !== 1'b1 || rd_addr_o !== 8'h20 + 8'(c)) begin
        mismatched++;
        $display("FAIL search_rd_mux: got en=%b addr=%h want en=1 addr=%h",
                 rd_en_o, rd_addr_o, 8'h20 + 8'(c));
      end
    end
    @(negedge clk_i);
    eng_task_ready_i = 3'b000;
    eng_rd_en_i = 3'b000;
    #1;
    compared++;
    if (nvalid != 3 || eng_task_valid_o !== 3'b000) begin
      mismatched++;
      $display("FAIL search_task_valid: got %0d cycles now=%b want 3 cycles now=000",
               nvalid, eng_task_valid_o);
    end
    compared++;
    if (eng_task_o.cmd.key !== 16'h1234 || eng_task_o.head_ptr !== 8'h40) begin
      mismatched++;
      $display("FAIL search_locked_task: got key=%h ptr=%h want 1234/40",
               eng_task_o.cmd.key, eng_task_o.head_ptr);
    end
    repeat (8) @(negedge clk_i);
    #1;
    compared++;
    if (result_valid_o !== 1'b0 || busy_o !== 1'b1) begin
      mismatched++;
      $display("FAIL search_wait: got rv=%b busy=%b want 0/1", result_valid_o, busy_o);
    end
    @(negedge clk_i);
    res = '0;
    res.cmd = task_i.cmd;
    res.rescode = LL_SEARCH_FOUND;
    res.chain_state = LL_IN_HEAD;
    eng_result_i[0] = res;
    eng_result_valid_i = 3'b001;
    result_ready_i = 1'b1;
    #1;
    compared++;
    if (result_o !== res || result_valid_o !== 1'b1 || eng_result_ready_o !== 3'b001) begin
      mismatched++;
      $display("FAIL search_result: got %h v=%b r=%b want %h v=1 r=001",
               result_o, result_valid_o, eng_result_ready_o, res);
    end
    @(negedge clk_i);
    clr();
    #1;
    compared++;
    if (busy_o !== 1'b0 || task_ready_o !== 1'b1 || proto_err_o !== 1'b0) begin
      mismatched++;
      $display("FAIL search_done: got busy=%b rdy=%b err=%b want 0/1/0",
               busy_o, task_ready_o, proto_err_o);
    end
  endtask

  task automatic test_back_to_back();
    ll_ht_result_t res;
    send_task(OP_INSERT, 16'h0101);
    eng_task_ready_i = 3'b010;
    #1;
    compared++;
    if (eng_task_valid_o !== 3'b010) begin
      mismatched++;
      $display("FAIL b2b_first_valid: got %b want 010", eng_task_valid_o);
    end
    @(negedge clk_i);
    eng_task_ready_i = 3'b000;
    res = '0;
    res.cmd.opcode = OP_INSERT;
    res.rescode = LL_INSERT_SUCCESS;
    res.chain_state = LL_IN_TAIL;
    eng_result_i[1] = res;
    eng_result_valid_i = 3'b010;
    result_ready_i = 1'b1;
    #1;
    compared++;
    if (result_o !== res || eng_result_ready_o !== 3'b010) begin
      mismatched++;
      $display("FAIL b2b_first_result: got %h r=%b want %h r=010",
               result_o, eng_result_ready_o, res);
    end
    @(negedge clk_i);
    clr();
    task_i.cmd.opcode = OP_INSERT;
    task_i.cmd.key = 16'h0202;
    task_valid_i = 1'b1;
    #1;
    compared++;
    if (task_ready_o !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_idle_ready: got %b want 1", task_ready_o);
    end
    @(negedge clk_i);
    task_valid_i = 1'b0;
    #1;
    compared++;
    if (eng_task_valid_o !== 3'b010 || eng_task_o.cmd.key !== 16'h0202) begin
      mismatched++;
      $display("FAIL b2b_second_dispatch: got %b key=%h want 010 key=0202",
               eng_task_valid_o, eng_task_o.cmd.key);
    end
    eng_task_ready_i = 3'b010;
    @(negedge clk_i);
    eng_task_ready_i = 3'b000;
    eng_result_i[1] = res;
    eng_result_valid_i = 3'b010;
    result_ready_i = 1'b1;
    @(negedge clk_i);
    clr();
    #1;
    compared++;
    if (busy_o !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_done: got busy=%b want 0", busy_o);
    end
  endtask

  task automatic test_delete_stray();
    ll_ram_data_t d0, d2;
    ll_ht_result_t res;
    d0 = '0; d0.key = 16'h7777; d0.next_ptr = 8'h01;
    d2 = '0; d2.key = 16'hBEEF; d2.next_ptr = 8'h33; d2.next_ptr_val = 1'b1;
    send_task(OP_DELETE, 16'hBEEF);
    eng_task_ready_i = 3'b100;
    #1;
    compared++;
    if (eng_task_valid_o !== 3'b100) begin
      mismatched++;
      $display("FAIL delete_valid: got %b want 100", eng_task_valid_o);
    end
    @(negedge clk_i);
    eng_task_ready_i = 3'b000;
    eng_wr_en_i = 3'b101;
    eng_wr_addr_i[2] = 8'h15;
    eng_wr_addr_i[0] = 8'h77;
    eng_wr_data_i[2] = d2;
    eng_wr_data_i[0] = d0;
    #1;
    compared++;
    if (wr_addr_o !== 8'h15 || wr_en_o !== 1'b1 || wr_data_o !== d2) begin
      mismatched++;
      $display("FAIL delete_wr_mux: got addr=%h en=%b data=%h want 15/1/%h",
               wr_addr_o, wr_en_o, wr_data_o, d2);
    end
    compared++;
    if (proto_err_o !== 1'b0) begin
      mismatched++;
      $display("FAIL delete_err_early: got %b want 0", proto_err_o);
    end
    @(negedge clk_i);
    eng_wr_en_i = 3'b000;
    #1;
    compared++;
    if (proto_err_o !== 1'b1) begin
      mismatched++;
      $display("FAIL delete_proto_err: got %b want 1", proto_err_o);
    end
    res = '0;
    res.cmd.opcode = OP_DELETE;
    res.rescode = LL_DELETE_SUCCESS;
    res.chain_state = LL_IN_MIDDLE;
    eng_result_i[2] = res;
    eng_result_valid_i = 3'b100;
    result_ready_i = 1'b1;
    #1;
    compared++;
    if (result_o !== res || eng_result_ready_o !== 3'b100) begin
      mismatched++;
      $display("FAIL delete_result: got %h r=%b want %h r=100",
               result_o, eng_result_ready_o, res);
    end
    @(negedge clk_i);
    clr();
    #1;
    compared++;
    if (busy_o !== 1'b0 || proto_err_o !== 1'b1) begin
      mismatched++;
      $display("FAIL delete_done: got busy=%b err=%b want 0/1", busy_o, proto_err_o);
    end
  endtask

  task automatic test_bad_op();
    int nhold;
    nhold = 0;
    send_task(2'd3, 16'hDEAD);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk_i);
      #1;
      if (result_valid_o === 1'b1 && eng_task_valid_o === 3'b000) nhold++;
    end
    compared++;
    if (nhold != 5) begin
      mismatched++;
      $display("FAIL badop_hold: got %0d cycles want 5", nhold);
    end
    compared++;
    if (result_o.rescode !== LL_DELETE_NOT_SUCCESS_NO_ENTRY ||
        result_o.chain_state !== LL_NO_CHAIN ||
        result_o.cmd.opcode !== 2'd3 || result_o.cmd.key !== 16'hDEAD) begin
      mismatched++;
      $display("FAIL badop_result: got %h want rescode=5 chain=0 op=3 key=dead",
               result_o);
    end
    @(negedge clk_i);
    result_ready_i = 1'b1;
    @(negedge clk_i);
    clr();
    #1;
    compared++;
    if (busy_o !== 1'b0 || result_valid_o !== 1'b0) begin
      mismatched++;
      $display("FAIL badop_done: got busy=%b rv=%b want 0/0", busy_o, result_valid_o);
    end
  endtask

  task automatic test_reset_mid();
    ll_ht_result_t res;
    send_task(OP_INSERT, 16'h0A0A);
    eng_task_ready_i = 3'b010;
    @(negedge clk_i);
    eng_task_ready_i = 3'b000;
    result_ready_i = 1'b1;
    eng_rd_en_i = 3'b010;
    eng_rd_addr_i[1] = 8'h5A;
    #1;
    compared++;
    if (eng_result_ready_o !== 3'b010 || rd_en_o !== 1'b1) begin
      mismatched++;
      $display("FAIL rstmid_pre: got r=%b rd=%b want 010/1", eng_result_ready_o, rd_en_o);
    end
    #1;
    rst_n_i = 1'b0;
    #1;
    compared++;
    if ({eng_result_ready_o, rd_en_o, busy_o, task_ready_o, proto_err_o,
         eng_task_valid_o, result_valid_o} !== 11'b0 || eng_task_o !== '0) begin
      mismatched++;
      $display("FAIL rstmid_async: got r=%b rd=%b busy=%b rdy=%b err=%b etv=%b rv=%b task=%h want all 0",
               eng_result_ready_o, rd_en_o, busy_o, task_ready_o, proto_err_o,
               eng_task_valid_o, result_valid_o, eng_task_o);
    end
    @(negedge clk_i);
    clr();
    rst_n_i = 1'b1;
    #1;
    compared++;
    if (task_ready_o !== 1'b1) begin
      mismatched++;
      $display("FAIL rstmid_release: got %b want 1", task_ready_o);
    end
    send_task(OP_INSERT, 16'h5555);
    compared++;
    if (eng_task_valid_o !== 3'b010 || eng_task_o.cmd.key !== 16'h5555) begin
      mismatched++;
      $display("FAIL rstmid_insert_dispatch: got %b key=%h want 010 key=5555",
               eng_task_valid_o, eng_task_o.cmd.key);
    end
    eng_task_ready_i = 3'b010;
    @(negedge clk_i);
    eng_task_ready_i = 3'b000;
    res = '0;
    res.cmd.opcode = OP_INSERT;
    res.cmd.key = 16'h5555;
    res.rescode = LL_INSERT_SUCCESS;
    res.chain_state = LL_IN_HEAD_TAIL;
    eng_result_i[1] = res;
    eng_result_valid_i = 3'b010;
    result_ready_i = 1'b1;
    #1;
    compared++;
    if (result_o !== res || result_valid_o !== 1'b1) begin
      mismatched++;
      $display("FAIL rstmid_insert_result: got %h v=%b want %h v=1",
               result_o, result_valid_o, res);
    end
    @(negedge clk_i);
    clr();
    #1;
    compared++;
    if (busy_o !== 1'b0 || proto_err_o !== 1'b0) begin
      mismatched++;
      $display("FAIL rstmid_done: got busy=%b err=%b want 0/0", busy_o, proto_err_o);
    end
  endtask

`ifdef LL_DATA_TABLE_CTRL_STATS_EN
  task automatic run_task(input ll_opcode_t op);
    logic [2:0] oh;
    oh = 3'b001 << op;
    send_task(op, 16'h0F0F);
    eng_task_ready_i = oh;
    @(negedge clk_i);
    eng_task_ready_i = 3'b000;
    eng_result_valid_i = oh;
    result_ready_i = 1'b1;
    @(negedge clk_i);
    clr();
  endtask

  task automatic test_stats();
    rst_n_i = 1'b0;
    #1;
    rst_n_i = 1'b1;
    repeat (3) run_task(OP_INSERT);
    repeat (2) run_task(OP_DELETE);
    #1;
    compared++;
    if (stat_insert_o !== 32'd3 || stat_delete_o !== 32'd2 || stat_search_o !== 32'd0) begin
      mismatched++;
      $display("FAIL stats_counts: got s=%0d i=%0d d=%0d want 0/3/2",
               stat_search_o, stat_insert_o, stat_delete_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_search();
    test_back_to_back();
    test_delete_stray();
    test_bad_op();
    test_reset_mid();
`ifdef LL_DATA_TABLE_CTRL_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
